// File: rtl/tt_pkg.sv
// Shared types and sizes for the truth table capture block.
// Holds the sweep FSM state encoding and the pattern/table widths.
package tt_pkg;

  localparam int N_INPUTS   = 7;
  localparam int N_PATTERNS = 128;
  localparam int TT_W       = 128;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DRIVE  = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/settle_timer.sv
// Settle countdown: load with SETTLE, count down while enabled.
// Ports: clk, rst_n, load, enable in; expired high on the last settle cycle.
module settle_timer #(
  parameter int unsigned SETTLE = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic enable,
  output logic expired
);

  logic [3:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 4'd0;
    end else if (load) begin
      cnt <= 4'(SETTLE);
    end else if (enable && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  // A count of one marks the final cycle of the hold window.
  assign expired = enable && (cnt == 4'd1);

endmodule

// File: rtl/truth_table_capture.sv
// Sweeps x_out over all 128 patterns and captures f_in into tt.
// Ports: start/abort control, expected in; x_out, busy, done, tt, weight, match out.
module truth_table_capture
  import tt_pkg::*;
#(
  parameter int unsigned SETTLE = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [TT_W-1:0]     expected,
  input  logic                f_in,
  output logic [N_INPUTS-1:0] x_out,
  output logic                busy,
  output logic                done,
  output logic [TT_W-1:0]     tt,
  output logic [7:0]          weight,
  output logic                match
);

  state_t                state;
  logic [N_INPUTS-1:0]   idx;
  logic [TT_W-1:0]       tt_nxt;
  logic                  last;
  logic                  accept;
  logic                  t_load;
  logic                  t_en;
  logic                  expired;

  assign last   = (idx == 7'(N_PATTERNS - 1));
  assign accept = (state == S_IDLE) && start && !abort;
  assign t_load = accept ||
                  ((state == S_SAMPLE) && !abort && !last);
  assign t_en   = (state == S_DRIVE);

  settle_timer #(
    .SETTLE (SETTLE)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (t_load),
    .enable  (t_en),
    .expired (expired)
  );

  // Table with the current pattern's bit replaced; also feeds the
  // match compare so the final bit is included at the DONE transition.
  always_comb begin
    tt_nxt      = tt;
    tt_nxt[idx] = f_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      idx    <= '0;
      tt     <= '0;
      weight <= 8'd0;
      match  <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            state  <= S_DRIVE;
            idx    <= '0;
            tt     <= '0;
            weight <= 8'd0;
            match  <= 1'b0;
          end
        end
        S_DRIVE: begin
          if (abort) begin
            state <= S_IDLE;
            idx   <= '0;
            match <= 1'b0;
          end else if (expired) begin
            state <= S_SAMPLE;
          end
        end
        S_SAMPLE: begin
          if (abort) begin
            state <= S_IDLE;
            idx   <= '0;
            match <= 1'b0;
          end else begin
            tt     <= tt_nxt;
            weight <= weight + {7'd0, f_in};
            if (last) begin
              state <= S_DONE;
              idx   <= '0;
              match <= (tt_nxt == expected);
            end else begin
              state <= S_DRIVE;
              idx   <= idx + 7'd1;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          idx   <= '0;
        end
      endcase
    end
  end

  // idx is forced to zero outside a sweep, so it doubles as x_out.
  assign x_out = idx;
  assign busy  = (state == S_DRIVE) || (state == S_SAMPLE);
  assign done  = (state == S_DONE);

endmodule

// File: tb/tb_truth_table_capture.sv
// Scoreboard bench for truth_table_capture.
// Stimulus queues expected sweep endings; a monitor pops and checks them.
module tb_truth_table_capture;

  localparam int S     = 1;
  localparam int SWEEP = 128 * (S + 1);
  localparam logic [127:0] MAJ_C =
    128'hfeeaeaa8eaaae888eee8aaa8eaa8a880;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         abort;
  logic [127:0] expected;
  logic         f_in;
  logic [6:0]   x_out;
  logic         busy;
  logic         done;
  logic [127:0] tt;
  logic [7:0]   weight;
  logic         match;

  truth_table_capture #(
    .SETTLE (S)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .expected (expected),
    .f_in     (f_in),
    .x_out    (x_out),
    .busy     (busy),
    .done     (done),
    .tt       (tt),
    .weight   (weight),
    .match    (match)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Function under test: 0 zero, 1 x0, 2 tabulated network,
  // 3 one, 4 random table.
  int           mode = 0;
  logic [127:0] rnd_tt = '0;
  logic [127:0] maj_tt = MAJ_C;

  function automatic logic fval(int m, logic [6:0] x,
                                logic [127:0] r,
                                logic [127:0] mj);
    case (m)
      0:       return 1'b0;
      1:       return x[0];
      2:       return mj[x];
      3:       return 1'b1;
      default: return r[x];
    endcase
  endfunction

  assign f_in = fval(mode, x_out, rnd_tt, maj_tt);

  // Reference: tabulate the function over every pattern.
  function automatic logic [127:0] model_tt(int m);
    logic [127:0] t;
    t = '0;
    for (int i = 0; i < 128; i++)
      t[i] = fval(m, 7'(i), rnd_tt, maj_tt);
    return t;
  endfunction

  typedef struct {
    int           kind;
    int           end_cyc;
    logic [127:0] tt;
    logic [7:0]   w;
    logic         m;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic void chk(string name, logic [127:0] act,
                              logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endfunction

  // Monitor: every busy fall ends a sweep (done, abort or reset).
  logic pb = 1'b0;
  exp_t e;
  initial begin
    forever begin
      @(negedge clk);
      if (pb && !busy) begin
        if (q.size() == 0) begin
          chk("unexpected_end", 1, 0);
        end else begin
          e = q.pop_front();
          chk("end_done", done, (e.kind == 0));
          chk("end_cycle", cyc, e.end_cyc);
          chk("tt", tt, e.tt);
          chk("weight", weight, e.w);
          chk("match", match, e.m);
        end
      end
      pb = busy;
    end
  end

  task automatic wait_end(bit start_at_done);
    int n;
    n = 0;
    while (busy && n < SWEEP + 50) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("timeout", busy, 0);
    if (start_at_done) begin
      chk("done_seen", done, 1);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("start_in_done", busy, 0);
    end
    @(negedge clk);
  endtask

  task automatic run_sweep(int m, logic [127:0] exp_in,
                           logic [127:0] exp_tt,
                           bit pulse_mid, bit start_at_done);
    exp_t r;
    @(negedge clk);
    mode     = m;
    expected = exp_in;
    start    = 1'b1;
    r.kind    = 0;
    r.end_cyc = cyc + 1 + SWEEP;
    r.tt      = exp_tt;
    r.w       = 8'($countones(exp_tt));
    r.m       = (exp_tt == exp_in);
    q.push_back(r);
    @(negedge clk);
    start = 1'b0;
    if (pulse_mid) begin
      repeat (40) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    wait_end(start_at_done);
  endtask

  task automatic wait_x(logic [6:0] v);
    int n;
    n = 0;
    while (x_out != v && n < SWEEP) begin
      @(negedge clk);
      n++;
    end
    if (x_out != v) chk("reach_x", x_out, v);
  endtask

  task automatic abort_test();
    exp_t         r;
    logic [127:0] full;
    @(negedge clk);
    rnd_tt   = {$urandom, $urandom, $urandom, $urandom};
    mode     = 4;
    expected = '0;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_x(7'd50);
    abort = 1'b1;
    full  = model_tt(4);
    r.kind    = 1;
    r.end_cyc = cyc + 1;
    r.tt      = full & {78'd0, {50{1'b1}}};
    r.w       = 8'($countones(r.tt));
    r.m       = 1'b0;
    q.push_back(r);
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    wait_end(1'b0);
  endtask

  task automatic reset_test();
    exp_t r;
    int   seen;
    @(negedge clk);
    mode  = 3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_x(7'd100);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_x", x_out, 0);
    chk("rst_tt", tt, 0);
    chk("rst_w", weight, 0);
    chk("rst_m", match, 0);
    r.kind    = 1;
    r.end_cyc = cyc + 1;
    r.tt      = '0;
    r.w       = 8'd0;
    r.m       = 1'b0;
    q.push_back(r);
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    seen = 0;
    repeat (SWEEP + 20) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    chk("idle_after_reset", seen, 0);
  endtask

  logic [127:0] t;
  logic [127:0] flip;

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    abort    = 1'b0;
    expected = '0;
    #2;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_tt", tt, 0);
    chk("reset_w", weight, 0);
    chk("reset_x", x_out, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_sweep(0, '0, '0, 1'b0, 1'b0);
    run_sweep(1, '0, {32{4'hA}}, 1'b0, 1'b0);
    run_sweep(2, MAJ_C, MAJ_C, 1'b0, 1'b0);
    flip = MAJ_C ^ (128'd1 << 37);
    run_sweep(2, flip, MAJ_C, 1'b1, 1'b0);
    run_sweep(3, '0, {128{1'b1}}, 1'b0, 1'b1);

    for (int k = 0; k < 3; k++) begin
      rnd_tt = {$urandom, $urandom, $urandom, $urandom};
      t = model_tt(4);
      if ($urandom_range(1, 0) == 1)
        run_sweep(4, t, t, 1'b0, 1'b0);
      else
        run_sweep(4, {$urandom, $urandom, $urandom, $urandom},
                  t, 1'b0, 1'b0);
    end

    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort_idle", busy, 0);

    abort_test();
    reset_test();
    run_sweep(1, {32{4'hA}}, {32{4'hA}}, 1'b0, 1'b0);

    repeat (4) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
